// File: rtl/fp_wire_pkg.sv
// -----------------------------------------------------------------------------
// Package fp_wire
// Shared types and constants for the FP operand-preparation path.
//   fp_opnd_in_type  : raw operand set as it arrives from the register file
//   fp_opnd_out_type : prepared operand set plus per-operand unbox flags
//   FP_CANON_NAN_S   : single-precision canonical quiet NaN, NaN-boxed to 64 bits
// The op tag is kept out of these structs because its width is a parameter
// of the stage.
// -----------------------------------------------------------------------------
package fp_wire;

    localparam logic [63:0] FP_CANON_NAN_S = 64'hFFFFFFFF_7FC00000;
    localparam logic [1:0]  FP_FMT_S       = 2'd0;

    typedef struct packed {
        logic [63:0] data1;
        logic [63:0] data2;
        logic [63:0] data3;
        logic [1:0]  fmt;
        logic [2:0]  rm;
    } fp_opnd_in_type;

    typedef struct packed {
        logic [63:0] data1;
        logic [63:0] data2;
        logic [63:0] data3;
        logic [1:0]  fmt;
        logic [2:0]  rm;
        logic [2:0]  unbox;
    } fp_opnd_out_type;

    // A single-precision value is legal only when its upper word is all ones.
    function automatic logic fp_is_boxed(input logic [63:0] data);
        return (data[63:32] == 32'hFFFFFFFF);
    endfunction

endpackage

// File: rtl/fp_nanbox_chk.sv
// -----------------------------------------------------------------------------
// fp_nanbox_chk
// Combinational NaN-box check for one operand.
// Ports:
//   i_data  [63:0] raw register value
//   i_fmt   [1:0]  0=single, 1=double, 2/3=reserved
//   o_data  [63:0] operand to forward (canonical NaN if a single is mis-boxed)
//   o_unbox        1 when the operand was replaced
// -----------------------------------------------------------------------------
module fp_nanbox_chk
    import fp_wire::*;
(
    input  logic [63:0] i_data,
    input  logic [1:0]  i_fmt,
    output logic [63:0] o_data,
    output logic        o_unbox
);

    logic w_bad;

    // Only single-precision operands carry a boxing requirement; doubles and
    // reserved formats pass through untouched.
    assign w_bad   = (i_fmt == FP_FMT_S) && !fp_is_boxed(i_data);
    assign o_data  = w_bad ? FP_CANON_NAN_S : i_data;
    assign o_unbox = w_bad;

endmodule

// File: rtl/fp_opnd_stage.sv
// -----------------------------------------------------------------------------
// fp_opnd_stage
// Operand-preparation register stage ahead of the sign-injection / misc FP
// units. Three operands are NaN-box checked on the input side and the checked
// result is registered together with fmt/rm/op.
//
// Build option: FP_OPND_SKID_EN
//   defined   : 2-entry skid buffer (EMPTY/ONE/TWO), in_ready comes straight
//               from the state register, so out_ready never reaches in_ready
//               combinationally.
//   undefined : single register, in_ready = ~out_valid | out_ready.
//
// Handshake: a set moves across an interface on any rising clock edge where
// that interface's valid and ready are both high. valid never depends on ready
// of the same interface; once out_valid is high, every out_* field stays
// stable until the transfer happens.
//
// Ports:
//   clock, reset (async, active low)
//   in_valid/in_ready, in_data1..3 [63:0], in_fmt [1:0], in_rm [2:0], in_op [OPW-1:0]
//   out_valid/out_ready, out_data1..3 [63:0], out_fmt, out_rm, out_op,
//   out_unbox [2:0] (bit i = operand i+1 replaced)
//   dbg_state [1:0]: skid build 0=EMPTY 1=ONE 2=TWO; single-register build
//                    0=empty 1=full
// -----------------------------------------------------------------------------
module fp_opnd_stage
    import fp_wire::*;
#(
    parameter int OPW = 5
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [63:0]    in_data1,
    input  logic [63:0]    in_data2,
    input  logic [63:0]    in_data3,
    input  logic [1:0]     in_fmt,
    input  logic [2:0]     in_rm,
    input  logic [OPW-1:0] in_op,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [63:0]    out_data1,
    output logic [63:0]    out_data2,
    output logic [63:0]    out_data3,
    output logic [1:0]     out_fmt,
    output logic [2:0]     out_rm,
    output logic [OPW-1:0] out_op,
    output logic [2:0]     out_unbox,
    output logic [1:0]     dbg_state
);

    fp_opnd_in_type  w_in_raw;
    fp_opnd_out_type w_in_chk;
    logic [63:0]     w_d1_chk, w_d2_chk, w_d3_chk;
    logic            w_u1, w_u2, w_u3;
    logic            w_in_xfer, w_out_xfer;
    logic            w_in_ready, w_out_valid;
    fp_opnd_out_type r_main;
    logic [OPW-1:0]  r_main_op;

    always_comb begin
        w_in_raw.data1 = in_data1;
        w_in_raw.data2 = in_data2;
        w_in_raw.data3 = in_data3;
        w_in_raw.fmt   = in_fmt;
        w_in_raw.rm    = in_rm;
    end

    fp_nanbox_chk u_chk1 (.i_data(w_in_raw.data1), .i_fmt(w_in_raw.fmt), .o_data(w_d1_chk), .o_unbox(w_u1));
    fp_nanbox_chk u_chk2 (.i_data(w_in_raw.data2), .i_fmt(w_in_raw.fmt), .o_data(w_d2_chk), .o_unbox(w_u2));
    fp_nanbox_chk u_chk3 (.i_data(w_in_raw.data3), .i_fmt(w_in_raw.fmt), .o_data(w_d3_chk), .o_unbox(w_u3));

    always_comb begin
        w_in_chk.data1 = w_d1_chk;
        w_in_chk.data2 = w_d2_chk;
        w_in_chk.data3 = w_d3_chk;
        w_in_chk.fmt   = w_in_raw.fmt;
        w_in_chk.rm    = w_in_raw.rm;
        w_in_chk.unbox = {w_u3, w_u2, w_u1};
    end

    assign w_in_xfer  = in_valid & w_in_ready;
    assign w_out_xfer = w_out_valid & out_ready;

`ifdef FP_OPND_SKID_EN

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]      r_state;
    fp_opnd_out_type r_skid;
    logic [OPW-1:0]  r_skid_op;

    // Both handshake signals decode the state register only.
    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_in_ready  = (r_state != ST_TWO);
    assign dbg_state   = r_state;

    // r_main always holds the oldest set; r_skid holds the younger one in TWO.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_EMPTY;
            r_main    <= '0;
            r_main_op <= '0;
            r_skid    <= '0;
            r_skid_op <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        r_main    <= w_in_chk;
                        r_main_op <= in_op;
                        r_state   <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_in_xfer && w_out_xfer) begin
                        r_main    <= w_in_chk;
                        r_main_op <= in_op;
                    end else if (w_in_xfer) begin
                        r_skid    <= w_in_chk;
                        r_skid_op <= in_op;
                        r_state   <= ST_TWO;
                    end else if (w_out_xfer) begin
                        r_state   <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_out_xfer) begin
                        r_main    <= r_skid;
                        r_main_op <= r_skid_op;
                        r_state   <= ST_ONE;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

`else

    logic r_valid;

    assign w_out_valid = r_valid;
    assign w_in_ready  = ~r_valid | out_ready;
    assign dbg_state   = {1'b0, r_valid};

    // A simultaneous input and output transfer simply reloads the register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid   <= 1'b0;
            r_main    <= '0;
            r_main_op <= '0;
        end else if (w_in_xfer) begin
            r_valid   <= 1'b1;
            r_main    <= w_in_chk;
            r_main_op <= in_op;
        end else if (w_out_xfer) begin
            r_valid   <= 1'b0;
        end
    end

`endif

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data1 = r_main.data1;
    assign out_data2 = r_main.data2;
    assign out_data3 = r_main.data3;
    assign out_fmt   = r_main.fmt;
    assign out_rm    = r_main.rm;
    assign out_unbox = r_main.unbox;
    assign out_op    = r_main_op;

endmodule

// File: tb/tb_fp_opnd_stage.sv
// -----------------------------------------------------------------------------
// tb_fp_opnd_stage
// Directed table of single-transfer vectors, followed by back-pressure,
// throughput and mid-operation reset sequences. Works in both builds
// (FP_OPND_SKID_EN defined or not).
// -----------------------------------------------------------------------------
module tb_fp_opnd_stage;

  localparam int OPW = 5;
  localparam int PW  = 205;
`ifdef FP_OPND_SKID_EN
  localparam int   EXP_ACC   = 2;
  localparam logic [1:0] EXP_FULL_ST = 2'd2;
`else
  localparam int   EXP_ACC   = 1;
  localparam logic [1:0] EXP_FULL_ST = 2'd1;
`endif
  localparam logic [63:0] CNAN = 64'hFFFFFFFF_7FC00000;

  // ---------------- clock / reset ----------------
  logic           clock = 1'b0;
  logic           reset;
  logic           in_valid, in_ready;
  logic [63:0]    in_data1, in_data2, in_data3;
  logic [1:0]     in_fmt;
  logic [2:0]     in_rm;
  logic [OPW-1:0] in_op;
  logic           out_valid, out_ready;
  logic [63:0]    out_data1, out_data2, out_data3;
  logic [1:0]     out_fmt;
  logic [2:0]     out_rm;
  logic [OPW-1:0] out_op;
  logic [2:0]     out_unbox;
  logic [1:0]     dbg_state;
  logic [PW-1:0]  out_pack;

  always #5 clock = ~clock;

  fp_opnd_stage #(.OPW(OPW)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
    .in_fmt(in_fmt), .in_rm(in_rm), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3),
    .out_fmt(out_fmt), .out_rm(out_rm), .out_op(out_op),
    .out_unbox(out_unbox), .dbg_state(dbg_state)
  );

  assign out_pack = {out_data1, out_data2, out_data3, out_fmt, out_rm, out_op, out_unbox};

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [PW-1:0] exp_q[$];
  int seq_id = 0;

  typedef struct {
    logic [63:0]    d1, d2, d3;
    logic [1:0]     fmt;
    logic [2:0]     rm;
    logic [OPW-1:0] op;
    logic [63:0]    e1, e2, e3;
    logic [2:0]     eu;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference box rule, used only to build expectations for generated streams.
  function automatic logic [PW-1:0] model(input logic [63:0] d1, input logic [63:0] d2,
                                          input logic [63:0] d3, input logic [1:0] fmt,
                                          input logic [2:0] rm, input logic [OPW-1:0] op);
    logic [63:0] o1, o2, o3;
    logic [2:0]  u;
    u  = 3'b000;
    o1 = d1; o2 = d2; o3 = d3;
    if (fmt == 2'd0) begin
      if (d1[63:32] != 32'hFFFFFFFF) begin o1 = CNAN; u[0] = 1'b1; end
      if (d2[63:32] != 32'hFFFFFFFF) begin o2 = CNAN; u[1] = 1'b1; end
      if (d3[63:32] != 32'hFFFFFFFF) begin o3 = CNAN; u[2] = 1'b1; end
    end
    return {o1, o2, o3, fmt, rm, op, u};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_vec(input vec_t v);
    in_data1 = v.d1; in_data2 = v.d2; in_data3 = v.d3;
    in_fmt = v.fmt; in_rm = v.rm; in_op = v.op;
  endtask

  // Stream element k of the current sequence: alternates fmt 0/1, operand 2
  // is mis-boxed for single, operands 1 and 3 are boxed.
  task automatic drive_stream(input int k);
    logic [31:0] tag;
    tag = 32'(seq_id * 256 + k);
    in_data1 = {32'hFFFFFFFF, 16'hA000, tag[15:0]};
    in_data2 = {tag, 32'h3F800000};
    in_data3 = {32'hFFFFFFFF, tag ^ 32'h5555AAAA};
    in_fmt   = 2'(k % 2);
    in_rm    = 3'(k % 8);
    in_op    = OPW'(k + seq_id);
  endtask

  task automatic send_one(input string name, input vec_t v);
    @(negedge clock);
    drive_vec(v);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    #1;
    check({name, ".in_ready"}, 256'(in_ready), 256'(1));
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    check({name, ".valid"}, 256'(out_valid), 256'(1));
    check({name, ".data"}, 256'(out_pack), 256'({v.e1, v.e2, v.e3, v.fmt, v.rm, v.op, v.eu}));
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    check({name, ".drained"}, 256'(out_valid), 256'(0));
  endtask

  // Streams n sets; out_ready stays low for the first `stall` cycles.
  task automatic run_stream(input int n, input int stall, output int acc_at_stall,
                            output logic ir_at_stall, output int first_out,
                            output int last_out, output int n_out);
    int k = 0;
    int cyc = 0;
    logic [PW-1:0] snap = '0;
    logic snap_v = 1'b0;
    n_out = 0; first_out = -1; last_out = -1;
    acc_at_stall = 0; ir_at_stall = 1'b1;
    seq_id++;
    while ((k < n || n_out < n) && cyc < 200) begin
      @(negedge clock);
      in_valid  = (k < n);
      drive_stream(k);
      out_ready = (cyc >= stall);
      #1;
      if (snap_v) check("hold_stable", 256'(out_pack), 256'(snap));
      snap_v = out_valid & ~out_ready;
      snap   = out_pack;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 256'(out_pack), 256'(0));
        end else begin
          check("order", 256'(out_pack), 256'(exp_q.pop_front()));
        end
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        n_out++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_data1, in_data2, in_data3, in_fmt, in_rm, in_op));
        k++;
      end
      if (cyc == stall - 1) begin
        acc_at_stall = k;
        ir_at_stall  = in_ready;
      end
      cyc++;
    end
    if (cyc >= 200) check("stream_timeout", 256'(cyc), 256'(0));
    @(negedge clock);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  int acc, first_o, last_o, nout;
  logic ir;

  initial begin
    vecs[0] = '{64'hFFFFFFFF_3F800000, 64'h00000000_3F800000, 64'hFFFFFFFF_40000000, 2'd0, 3'd0, 5'd1,
                64'hFFFFFFFF_3F800000, CNAN, 64'hFFFFFFFF_40000000, 3'b010};
    vecs[1] = '{64'h00000000_3F800000, 64'h3FF00000_00000000, 64'h0, 2'd1, 3'd1, 5'd2,
                64'h00000000_3F800000, 64'h3FF00000_00000000, 64'h0, 3'b000};
    vecs[2] = '{64'h0, 64'h7FFFFFFF_FFFFFFFF, 64'hFFFFFFFE_00000000, 2'd0, 3'd2, 5'd31,
                CNAN, CNAN, CNAN, 3'b111};
    vecs[3] = '{64'h00000000_00001234, 64'h12345678_9ABCDEF0, 64'h0, 2'd2, 3'd3, 5'd16,
                64'h00000000_00001234, 64'h12345678_9ABCDEF0, 64'h0, 3'b000};
    vecs[4] = '{64'hDEADBEEF_CAFEF00D, 64'h0, 64'h1, 2'd3, 3'd7, 5'd7,
                64'hDEADBEEF_CAFEF00D, 64'h0, 64'h1, 3'b000};
    vecs[5] = '{64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_7FC00000, 64'hFFFF0000_00000000, 2'd0, 3'd4, 5'd9,
                64'hFFFFFFFF_FFFFFFFF, CNAN, CNAN, 3'b100};

    // Reset held with in_valid high: nothing may be captured.
    reset = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    drive_vec(vecs[0]);
    repeat (3) @(negedge clock);
    check("rst.out_valid", 256'(out_valid), 256'(0));
    check("rst.in_ready", 256'(in_ready), 256'(1));
    check("rst.outputs", 256'(out_pack), 256'(0));
    check("rst.state", 256'(dbg_state), 256'(0));
    reset = 1'b1;
    in_valid = 1'b0;

    // Table-driven single transfers.
    for (int i = 0; i < 6; i++) send_one($sformatf("vec%0d", i), vecs[i]);

    // Back-pressure: 4 sets, 5 stalled cycles.
    run_stream(4, 5, acc, ir, first_o, last_o, nout);
    check("bp.accepted_while_stalled", 256'(acc), 256'(EXP_ACC));
    check("bp.in_ready_while_stalled", 256'(ir), 256'(0));
    check("bp.outputs", 256'(nout), 256'(4));
    check("bp.queue_empty", 256'(exp_q.size()), 256'(0));

    // Throughput: 16 sets with out_ready continuously high.
    run_stream(16, 0, acc, ir, first_o, last_o, nout);
    check("tp.outputs", 256'(nout), 256'(16));
    check("tp.consecutive", 256'(last_o - first_o), 256'(15));
    check("tp.queue_empty", 256'(exp_q.size()), 256'(0));

    // Reset while full: fill with out_ready low, then assert reset.
    seq_id++;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      in_valid = 1'b1; out_ready = 1'b0;
      drive_stream(k);
    end
    @(negedge clock);
    #1;
    check("mid.full_state", 256'(dbg_state), 256'(EXP_FULL_ST));
    reset = 1'b0;
    #1;
    check("mid.out_valid", 256'(out_valid), 256'(0));
    check("mid.in_ready", 256'(in_ready), 256'(1));
    check("mid.outputs", 256'(out_pack), 256'(0));
    check("mid.state", 256'(dbg_state), 256'(0));
    @(negedge clock);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      check("mid.no_stale", 256'(out_valid), 256'(0));
    end
    out_ready = 1'b0;
    send_one("post_reset", vecs[2]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
